lbdr_dr: RTL and testbench

LBDR_DR -- requirements
Module: lbdr_dr

---
 rtl/lbdr_dr.sv | 164 ++++++++++++++++
 tb/tb_lbdr_dr.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lbdr_dr.sv
// LBDR routing unit with deroute fallback and packet route locking.
// Routes a header once, holds the route for its payload, releases on tail.
module lbdr_dr #(
  parameter int COORD_W = 2,
  parameter int FID_W = 3,
  parameter logic [FID_W-1:0] HDR_ID = FID_W'(1),
  parameter logic [FID_W-1:0] TAIL_ID = FID_W'(4)
) (
  input  logic clk,
  input  logic rst,
  input  logic [7:0] cfg_rxy,
  input  logic [3:0] cfg_cx,
  input  logic [1:0] cfg_dr,
  input  logic [2*COORD_W-1:0] cfg_addr,
  input  logic valid_in,
  input  logic [FID_W-1:0] flit_id,
  input  logic [2*COORD_W-1:0] dst_addr,
  output logic [4:0] port,
  output logic busy,
  output logic derouted,
  output logic err_unroutable,
  output logic err_proto
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state, state_nx;

  logic [7:0] rxy;
  logic [3:0] cx;
  logic [1:0] dr;
  logic [2*COORD_W-1:0] addr;

  logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
  logic n, s, e, w;
  logic min_n, min_e, min_w, min_s;
  logic local_hit;
  logic [3:0] dr_oh;
  logic dr_ok;
  logic [4:0] rt_port;
  logic rt_der, rt_bad;

  logic [4:0] port_nx;
  logic der_nx, unr_nx, perr_nx;
  logic is_hdr, is_tail;

  // Configuration is only sampled while the block is held in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rxy <= cfg_rxy;
      cx <= cfg_cx;
      dr <= cfg_dr;
      addr <= cfg_addr;
    end
  end

  assign x_cur = addr[COORD_W-1:0];
  assign y_cur = addr[2*COORD_W-1:COORD_W];
  assign x_dst = dst_addr[COORD_W-1:0];
  assign y_dst = dst_addr[2*COORD_W-1:COORD_W];

  assign n = y_dst < y_cur;
  assign s = y_cur < y_dst;
  assign e = x_cur < x_dst;
  assign w = x_dst < x_cur;

  assign min_n = ((n & ~e & ~w) | (n & e & rxy[0]) | (n & w & rxy[1])) & cx[0];
  assign min_e = ((e & ~n & ~s) | (e & n & rxy[2]) | (e & s & rxy[3])) & cx[1];
  assign min_w = ((w & ~n & ~s) | (w & n & rxy[4]) | (w & s & rxy[5])) & cx[2];
  assign min_s = ((s & ~e & ~w) | (s & e & rxy[6]) | (s & w & rxy[7])) & cx[3];

  assign local_hit = ~n & ~e & ~w & ~s;

  // Deroute port as a one-hot in {S,W,E,N} order, aligned with cx
  always_comb begin
    dr_oh = 4'b0000;
    unique case (dr)
      2'd0: dr_oh = 4'b0001;
      2'd1: dr_oh = 4'b0010;
      2'd2: dr_oh = 4'b0100;
      2'd3: dr_oh = 4'b1000;
      default: dr_oh = 4'b0000;
    endcase
  end

  assign dr_ok = |(dr_oh & cx);

  // Route selection: local wins, then minimal set, then deroute
  always_comb begin
    rt_port = 5'b00000;
    rt_der = 1'b0;
    rt_bad = 1'b0;
    if (local_hit) begin
      rt_port = 5'b10000;
    end else if (min_n | min_e | min_w | min_s) begin
      rt_port = {1'b0, min_s, min_w, min_e, min_n};
    end else if (dr_ok) begin
      rt_port = {1'b0, dr_oh};
      rt_der = 1'b1;
    end else begin
      rt_bad = 1'b1;
    end
  end

  assign is_hdr = valid_in && (flit_id == HDR_ID);
  assign is_tail = valid_in && (flit_id == TAIL_ID);

  // Packet FSM: lock on header, hold on payload, release on tail
  always_comb begin
    state_nx = state;
    port_nx = port;
    der_nx = derouted;
    unr_nx = 1'b0;
    perr_nx = err_proto;
    unique case (state)
      IDLE: begin
        if (is_hdr) begin
          if (rt_bad) begin
            unr_nx = 1'b1;
          end else begin
            port_nx = rt_port;
            der_nx = rt_der;
            state_nx = LOCKED;
          end
        end else if (valid_in) begin
          perr_nx = 1'b1;
        end
      end
      LOCKED: begin
        if (is_hdr) begin
          perr_nx = 1'b1;
          port_nx = rt_port;
          der_nx = rt_der;
          unr_nx = rt_bad;
        end else if (is_tail) begin
          port_nx = 5'b00000;
          der_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      port <= 5'b00000;
      derouted <= 1'b0;
      err_unroutable <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      state <= state_nx;
      port <= port_nx;
      derouted <= der_nx;
      err_unroutable <= unr_nx;
      err_proto <= perr_nx;
    end
  end

  assign busy = (state == LOCKED);

endmodule

// File: tb/tb_lbdr_dr.sv
// Self-checking bench for lbdr_dr.
// Reference model feeds a scoreboard queue compared after each edge.
module tb_lbdr_dr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [7:0] cfg_rxy;
  logic [3:0] cfg_cx;
  logic [1:0] cfg_dr;
  logic [3:0] cfg_addr;
  logic valid_in;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic [4:0] port;
  logic busy, derouted, err_unroutable, err_proto;

  lbdr_dr dut (
    .clk(clk),
    .rst(rst),
    .cfg_rxy(cfg_rxy),
    .cfg_cx(cfg_cx),
    .cfg_dr(cfg_dr),
    .cfg_addr(cfg_addr),
    .valid_in(valid_in),
    .flit_id(flit_id),
    .dst_addr(dst_addr),
    .port(port),
    .busy(busy),
    .derouted(derouted),
    .err_unroutable(err_unroutable),
    .err_proto(err_proto)
  );

  localparam logic [2:0] HDR = 3'b001;
  localparam logic [2:0] TAIL = 3'b100;
  localparam logic [2:0] PAY = 3'b010;

  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  logic [7:0] m_rxy;
  logic [3:0] m_cx;
  logic [1:0] m_dr;
  logic [3:0] m_addr;
  logic m_locked, m_der, m_unr, m_perr;
  logic [4:0] m_port;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Returns {bad, derouted, port}
  function automatic logic [6:0] ref_route(input logic [3:0] d);
    int xc, yc, xd, yd;
    logic nn, ss, ee, ww, mn, me, mw, ms;
    logic [4:0] dp;
    xc = int'(m_addr[1:0]);
    yc = int'(m_addr[3:2]);
    xd = int'(d[1:0]);
    yd = int'(d[3:2]);
    nn = yd < yc;
    ss = yc < yd;
    ee = xc < xd;
    ww = xd < xc;
    if (!(nn || ss || ee || ww)) return {2'b00, 5'b10000};
    mn = nn && (ee ? m_rxy[0] : (ww ? m_rxy[1] : 1'b1)) && m_cx[0];
    me = ee && (nn ? m_rxy[2] : (ss ? m_rxy[3] : 1'b1)) && m_cx[1];
    mw = ww && (nn ? m_rxy[4] : (ss ? m_rxy[5] : 1'b1)) && m_cx[2];
    ms = ss && (ee ? m_rxy[6] : (ww ? m_rxy[7] : 1'b1)) && m_cx[3];
    if (mn || me || mw || ms) return {2'b00, 1'b0, ms, mw, me, mn};
    case (m_dr)
      2'd0: dp = 5'b00001;
      2'd1: dp = 5'b00010;
      2'd2: dp = 5'b00100;
      default: dp = 5'b01000;
    endcase
    if (m_cx[m_dr]) return {1'b0, 1'b1, dp};
    return {1'b1, 1'b0, 5'b00000};
  endfunction

  task automatic step(input string tag, input logic r, input logic v,
                      input logic [2:0] f, input logic [3:0] d);
    logic [6:0] rt;
    logic [8:0] ex;
    rst = r;
    valid_in = v;
    flit_id = f;
    dst_addr = d;
    m_unr = 1'b0;
    if (r) begin
      m_rxy = cfg_rxy;
      m_cx = cfg_cx;
      m_dr = cfg_dr;
      m_addr = cfg_addr;
      m_locked = 1'b0;
      m_port = 5'b0;
      m_der = 1'b0;
      m_perr = 1'b0;
    end else if (v && f == HDR) begin
      rt = ref_route(d);
      if (m_locked) begin
        m_perr = 1'b1;
        m_unr = rt[6];
        m_port = rt[4:0];
        m_der = rt[5];
      end else if (rt[6]) begin
        m_unr = 1'b1;
      end else begin
        m_locked = 1'b1;
        m_port = rt[4:0];
        m_der = rt[5];
      end
    end else if (v && m_locked && f == TAIL) begin
      m_locked = 1'b0;
      m_port = 5'b0;
      m_der = 1'b0;
    end else if (v && !m_locked) begin
      m_perr = 1'b1;
    end
    exp_q.push_back({m_port, m_locked, m_der, m_unr, m_perr});
    @(posedge clk);
    @(negedge clk);
    ex = exp_q.pop_front();
    chk(tag, 32'({port, busy, derouted, err_unroutable, err_proto}),
        32'(ex));
  endtask

  task automatic do_reset(input logic [3:0] cx, input logic [7:0] rxy,
                          input logic [1:0] drp, input logic [3:0] ad);
    cfg_cx = cx;
    cfg_rxy = rxy;
    cfg_dr = drp;
    cfg_addr = ad;
    step("reset", 1'b1, 1'b0, 3'b000, 4'h0);
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    flit_id = 3'b000;
    dst_addr = 4'h0;
    cfg_rxy = 8'h00;
    cfg_cx = 4'h0;
    cfg_dr = 2'd0;
    cfg_addr = 4'h0;
    @(negedge clk);

    do_reset(4'hF, 8'h3C, 2'd0, 4'h5);
    chk("rst_port", 32'(port), 32'(5'b00000));
    chk("rst_busy", 32'(busy), 32'd0);

    step("hdr_local", 1'b0, 1'b1, HDR, 4'h5);
    chk("local_port", 32'(port), 32'(5'b10000));
    chk("local_busy", 32'(busy), 32'd1);
    step("tail_local", 1'b0, 1'b1, TAIL, 4'h0);

    step("hdr_se", 1'b0, 1'b1, HDR, 4'hA);
    chk("se_port", 32'(port), 32'(5'b00010));
    step("pay1", 1'b0, 1'b1, PAY, 4'h0);
    step("idle_cyc", 1'b0, 1'b0, PAY, 4'h3);
    step("pay2", 1'b0, 1'b1, PAY, 4'hF);
    chk("se_hold", 32'(port), 32'(5'b00010));
    step("tail_se", 1'b0, 1'b1, TAIL, 4'h0);
    chk("tail_port", 32'(port), 32'(5'b00000));
    chk("tail_busy", 32'(busy), 32'd0);

    step("pay_idle", 1'b0, 1'b1, PAY, 4'h0);
    chk("perr_idle", 32'(err_proto), 32'd1);
    step("hdr_a", 1'b0, 1'b1, HDR, 4'h0);
    step("hdr_relock", 1'b0, 1'b1, HDR, 4'h5);
    chk("relock_port", 32'(port), 32'(5'b10000));
    step("pay_mid", 1'b0, 1'b1, PAY, 4'h0);

    cfg_cx = 4'h9;
    cfg_dr = 2'd3;
    step("cfg_ignored", 1'b0, 1'b1, PAY, 4'h0);
    do_reset(4'h9, 8'h3C, 2'd3, 4'h5);
    chk("abort_port", 32'(port), 32'(5'b00000));
    chk("abort_perr", 32'(err_proto), 32'd0);

    step("hdr_deroute", 1'b0, 1'b1, HDR, 4'h6);
    chk("der_port", 32'(port), 32'(5'b01000));
    chk("der_flag", 32'(derouted), 32'd1);
    step("tail_der", 1'b0, 1'b1, TAIL, 4'h0);

    do_reset(4'h1, 8'h3C, 2'd1, 4'h5);
    step("hdr_unr", 1'b0, 1'b1, HDR, 4'h6);
    chk("unr_pulse", 32'(err_unroutable), 32'd1);
    chk("unr_busy", 32'(busy), 32'd0);
    step("unr_clear", 1'b0, 1'b0, HDR, 4'h6);
    chk("unr_low", 32'(err_unroutable), 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] f;
      case ($urandom_range(0, 3))
        0: f = HDR;
        1: f = TAIL;
        2: f = PAY;
        default: f = 3'b000;
      endcase
      cfg_rxy = 8'($urandom);
      cfg_cx = 4'($urandom);
      cfg_dr = 2'($urandom);
      cfg_addr = 4'($urandom);
      step("rand", ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
           f, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
